// File: rtl/fp_check_pkg.sv
// Shared types and constants for the fp_check result checker.
// Defining FP_CHECK_HALT_EN adds the HALT state (stop on the first mismatch).
package fp_check_pkg;

    localparam logic [31:0] FP_CANON_NAN_S = 32'h7FC0_0000;
    localparam logic [63:0] FP_CANON_NAN_D = 64'h7FF8_0000_0000_0000;

    localparam int OPC_FCMP     = 6;
    localparam int OPC_FCVT_F2I = 9;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [1:0]  fmt;
        logic [9:0]  opcode;
        logic        last;
    } fp_check_entry_type;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DONE = 2'd1
`ifdef FP_CHECK_HALT_EN
        , ST_HALT = 2'd2
`endif
    } check_state_e;

    // A canonical NaN only has to agree on the bits that make it a quiet NaN;
    // compares and float-to-int conversions never produce one, so they stay exact.
    function automatic logic [63:0] result_diff(input fp_check_entry_type e,
                                                input logic [63:0]        res);
        logic [63:0] d;
        d = e.result ^ res;
        if (!e.opcode[OPC_FCVT_F2I] && !e.opcode[OPC_FCMP]) begin
            if (e.fmt == 2'd0 && res[31:0] == FP_CANON_NAN_S)
                d = {33'd0, d[30:22], 22'd0};
            else if (e.fmt != 2'd0 && res == FP_CANON_NAN_D)
                d = {1'b0, d[62:51], 51'd0};
        end
        return d;
    endfunction

endpackage

// File: rtl/fp_check_if.sv
// Feeder-side expected-entry push and fp_unit completion bundle for fp_check.
interface fp_check_if;
    import fp_check_pkg::*;

    logic        exp_valid;
    logic        exp_ready;
    logic [63:0] exp_result;
    logic [4:0]  exp_flags;
    logic [1:0]  exp_fmt;
    logic [9:0]  exp_opcode;
    logic        exp_last;
    logic        res_ready;
    logic [63:0] res_result;
    logic [4:0]  res_flags;

    modport master (
        output exp_valid, exp_result, exp_flags, exp_fmt, exp_opcode, exp_last,
        output res_ready, res_result, res_flags,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_result, exp_flags, exp_fmt, exp_opcode, exp_last,
        input  res_ready, res_result, res_flags,
        output exp_ready
    );

endinterface

// File: rtl/fp_check_fifo.sv
// Expected-entry FIFO for fp_check; pointers carry one extra wrap bit so
// full and empty are distinguishable without a counter.
module fp_check_fifo
    import fp_check_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push_i,
    input  fp_check_entry_type entry_i,
    input  logic               pop_i,
    output fp_check_entry_type head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int AW = $clog2(DEPTH);

    fp_check_entry_type mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, rd_ptr_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which
    // slots are live, so a flush only needs the pointers cleared.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/fp_check.sv
// Hardware result checker downstream of fp_unit: queues expected entries and
// scores each completion. FP_CHECK_HALT_EN stops checking at the first mismatch.
module fp_check
    import fp_check_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    fp_check_if.slave        chk,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             error,
    output logic             overrun,
    output logic             done,
    output logic             fail_valid,
    output logic [CNT_W-1:0] fail_index,
    output logic [63:0]      fail_expected,
    output logic [63:0]      fail_calc,
    output logic [4:0]       fail_flags_diff
);

    check_state_e       state_q, state_d;
    fp_check_entry_type head, entry;
    logic               fifo_full, fifo_empty, run;
    logic               push, pop, overrun_ev, mismatch;
    logic [63:0]        res_diff;
    logic [4:0]         flags_diff;

    logic [CNT_W-1:0]   pass_q, fail_q, fail_index_q;
    logic               error_q, overrun_q, fail_valid_q;
    logic [63:0]        fail_expected_q, fail_calc_q;
    logic [4:0]         fail_flags_diff_q;

    assign entry = '{result: chk.exp_result, flags: chk.exp_flags, fmt: chk.exp_fmt,
                     opcode: chk.exp_opcode, last: chk.exp_last};

    fp_check_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .entry_i (entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Completions arriving with nothing queued are overruns, never bypassed.
    assign push       = chk.exp_valid && chk.exp_ready;
    assign pop        = run && chk.res_ready && !fifo_empty;
    assign overrun_ev = run && chk.res_ready && fifo_empty;
    assign res_diff   = result_diff(head, chk.res_result);
    assign flags_diff = head.flags ^ chk.res_flags;
    assign mismatch   = (|res_diff) || (|flags_diff);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // NOTE: the default assignment first keeps this combinational block from
    // inferring a latch on paths that do not assign state_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (pop && head.last) state_d = ST_DONE;
`ifdef FP_CHECK_HALT_EN
                else if (pop && mismatch) state_d = ST_HALT;
`endif
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        run           = (state_q == ST_RUN);
        done          = (state_q == ST_DONE);
        chk.exp_ready = run && !fifo_full;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pass_q            <= '0;
            fail_q            <= '0;
            error_q           <= 1'b0;
            overrun_q         <= 1'b0;
            fail_valid_q      <= 1'b0;
            fail_index_q      <= '0;
            fail_expected_q   <= '0;
            fail_calc_q       <= '0;
            fail_flags_diff_q <= '0;
        end else begin
            if (pop && !mismatch && pass_q != '1) pass_q <= pass_q + 1'b1;
            if (pop &&  mismatch && fail_q != '1) fail_q <= fail_q + 1'b1;
            if (overrun_ev) overrun_q <= 1'b1;
            if (overrun_ev || (pop && mismatch)) error_q <= 1'b1;
            if (pop && mismatch && !fail_valid_q) begin
                fail_valid_q      <= 1'b1;
                fail_index_q      <= pass_q + fail_q;
                fail_expected_q   <= head.result;
                fail_calc_q       <= chk.res_result;
                fail_flags_diff_q <= flags_diff;
            end
        end
    end

    assign pass_count      = pass_q;
    assign fail_count      = fail_q;
    assign error           = error_q;
    assign overrun         = overrun_q;
    assign fail_valid      = fail_valid_q;
    assign fail_index      = fail_index_q;
    assign fail_expected   = fail_expected_q;
    assign fail_calc       = fail_calc_q;
    assign fail_flags_diff = fail_flags_diff_q;

endmodule

// File: tb/tb_fp_check.sv
// Directed, table-driven bench for fp_check: compare rules, capture, full/overrun,
// last marker and asynchronous reset. Expectations follow FP_CHECK_HALT_EN.
module tb_fp_check;
    import fp_check_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;
    localparam logic [9:0] FADD = 10'b00_0000_0001;
    localparam logic [9:0] FMUL = 10'b00_0000_0100;
    localparam logic [9:0] FCMP = 10'b00_0100_0000;
    localparam logic [9:0] FCVT = 10'b10_0000_0000;
    localparam logic [63:0] THREE = 64'h0000_0000_4040_0000;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] pass_count, fail_count, fail_index;
    logic             error, overrun, done, fail_valid;
    logic [63:0]      fail_expected, fail_calc;
    logic [4:0]       fail_flags_diff;

    int n_checks = 0;
    int n_errors = 0;

    fp_check_if bus ();

    fp_check #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .chk             (bus),
        .pass_count      (pass_count),
        .fail_count      (fail_count),
        .error           (error),
        .overrun         (overrun),
        .done            (done),
        .fail_valid      (fail_valid),
        .fail_index      (fail_index),
        .fail_expected   (fail_expected),
        .fail_calc       (fail_calc),
        .fail_flags_diff (fail_flags_diff)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] e_res;
        logic [4:0]  e_flg;
        logic [1:0]  fmt;
        logic [9:0]  opc;
        logic [63:0] r_res;
        logic [4:0]  r_flg;
        bit          bad;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_entry(input logic [63:0] r, input logic [4:0] f, input logic [1:0] fmt,
                             input logic [9:0] op, input logic last);
        bus.exp_result = r;
        bus.exp_flags  = f;
        bus.exp_fmt    = fmt;
        bus.exp_opcode = op;
        bus.exp_last   = last;
    endtask

    task automatic push(input logic [63:0] r, input logic [4:0] f, input logic [1:0] fmt,
                        input logic [9:0] op, input logic last);
        int n = 0;
        while (!bus.exp_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (!bus.exp_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL push_timeout: exp_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            set_entry(r, f, fmt, op, last);
            bus.exp_valid = 1'b1;
            @(posedge clock); #1;
            bus.exp_valid = 1'b0;
        end
    endtask

    task automatic complete(input logic [63:0] r, input logic [4:0] f);
        bus.res_result = r;
        bus.res_flags  = f;
        bus.res_ready  = 1'b1;
        @(posedge clock); #1;
        bus.res_ready  = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        bit          halt_en, halted, have_fail;
        int          m_pass, m_fail, m_idx;
        logic [63:0] m_exp, m_calc;
        logic [4:0]  m_fdiff;

`ifdef FP_CHECK_HALT_EN
        halt_en = 1'b1;
`else
        halt_en = 1'b0;
`endif
        vecs[0] = '{THREE, 5'b0, 2'd0, FADD, THREE, 5'b0, 1'b0};
        vecs[1] = '{THREE, 5'b0, 2'd0, FADD, THREE, 5'b0, 1'b0};
        vecs[2] = '{THREE, 5'b0, 2'd0, FADD, THREE, 5'b0, 1'b0};
        vecs[3] = '{64'h7FC0_0001, 5'b0, 2'd0, FADD, 64'h7FC0_0000, 5'b0, 1'b0};
        vecs[4] = '{THREE, 5'b00001, 2'd0, FADD, THREE, 5'b00000, 1'b1};
        vecs[5] = '{64'h7FC0_0001, 5'b0, 2'd0, FCVT, 64'h7FC0_0000, 5'b0, 1'b1};
        vecs[6] = '{64'h7FF8_0000_0000_0001, 5'b0, 2'd1, FADD, 64'h7FF8_0000_0000_0000, 5'b0, 1'b0};
        vecs[7] = '{64'h7FF8_0000_0000_0001, 5'b0, 2'd1, FCMP, 64'h7FF8_0000_0000_0000, 5'b0, 1'b1};
        vecs[8] = '{64'hFFC0_0000, 5'b0, 2'd0, FADD, 64'h7FC0_0000, 5'b0, 1'b0};
        vecs[9] = '{64'h3FF0_0000_0000_0000, 5'b10000, 2'd1, FMUL,
                    64'h3FF0_0000_0000_0000, 5'b10000, 1'b0};

        bus.exp_valid = 1'b0;
        bus.res_ready = 1'b0;
        set_entry('0, '0, '0, '0, 1'b0);
        bus.res_result = '0;
        bus.res_flags  = '0;

        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;

        check("reset_exp_ready", bus.exp_ready, 1);
        check("reset_done", done, 0);
        check("reset_pass", pass_count, 0);
        check("reset_fail", fail_count, 0);
        check("reset_error", error, 0);
        check("reset_overrun", overrun, 0);
        check("reset_fail_valid", fail_valid, 0);

        // Compare rules: push one entry, complete it, score against the table.
        halted = 1'b0; have_fail = 1'b0;
        m_pass = 0; m_fail = 0; m_idx = 0; m_exp = '0; m_calc = '0; m_fdiff = '0;
        for (int i = 0; i < 10; i++) begin
            if (!halted) begin
                push(vecs[i].e_res, vecs[i].e_flg, vecs[i].fmt, vecs[i].opc, 1'b0);
                complete(vecs[i].r_res, vecs[i].r_flg);
                if (vecs[i].bad) begin
                    m_fail++;
                    if (!have_fail) begin
                        have_fail = 1'b1;
                        m_idx     = i;
                        m_exp     = vecs[i].e_res;
                        m_calc    = vecs[i].r_res;
                        m_fdiff   = vecs[i].e_flg ^ vecs[i].r_flg;
                    end
                    if (halt_en) halted = 1'b1;
                end else begin
                    m_pass++;
                end
            end
            check($sformatf("vec%0d_pass", i), pass_count, m_pass);
            check($sformatf("vec%0d_fail", i), fail_count, m_fail);
        end
        check("cmp_error", error, 1);
        check("cmp_fail_valid", fail_valid, 1);
        check("cmp_fail_index", fail_index, m_idx);
        check("cmp_fail_index_is_4", fail_index, 4);
        check("cmp_fail_expected", fail_expected, m_exp);
        check("cmp_fail_calc", fail_calc, m_calc);
        check("cmp_fail_flags_diff", fail_flags_diff, m_fdiff);
        check("cmp_done", done, 0);
        check("cmp_exp_ready", bus.exp_ready, !halt_en);
        check("cmp_overrun", overrun, 0);

        // Full FIFO: a push alongside a pop while full must be refused.
        pulse_reset();
        for (int i = 0; i < DEPTH; i++) push(THREE, 5'b0, 2'd0, FADD, 1'b0);
        check("full_exp_ready", bus.exp_ready, 0);
        set_entry(THREE, 5'b0, 2'd0, FADD, 1'b0);
        bus.exp_valid  = 1'b1;
        bus.res_result = THREE;
        bus.res_flags  = 5'b0;
        bus.res_ready  = 1'b1;
        @(posedge clock); #1;
        bus.exp_valid = 1'b0;
        bus.res_ready = 1'b0;
        check("full_pop_pass", pass_count, 1);
        check("full_after_pop_ready", bus.exp_ready, 1);
        for (int i = 0; i < DEPTH - 1; i++) complete(THREE, 5'b0);
        check("drain_pass", pass_count, DEPTH);
        check("drain_overrun_clear", overrun, 0);
        complete(THREE, 5'b0);
        check("ovr_overrun", overrun, 1);
        check("ovr_error", error, 1);
        check("ovr_pass_unchanged", pass_count, DEPTH);
        check("ovr_fail_unchanged", fail_count, 0);

        // Last marker: done one edge after the 5th completion, then frozen.
        pulse_reset();
        for (int i = 0; i < 5; i++) push(THREE + i, 5'b0, 2'd0, FADD, i == 4);
        for (int i = 0; i < 4; i++) complete(THREE + i, 5'b0);
        check("last_done_early", done, 0);
        check("last_pass4", pass_count, 4);
        complete(THREE + 4, 5'b0);
        check("last_done", done, 1);
        check("last_pass5", pass_count, 5);
        check("last_exp_ready", bus.exp_ready, 0);
        complete(64'h0, 5'b11111);
        check("frozen_pass", pass_count, 5);
        check("frozen_fail", fail_count, 0);
        check("frozen_overrun", overrun, 0);
        check("frozen_error", error, 0);
        check("frozen_done", done, 1);

        // Asynchronous reset with entries still queued.
        pulse_reset();
        for (int i = 0; i < 4; i++) push(THREE, 5'b0, 2'd0, FADD, 1'b0);
        complete(THREE, 5'b0);
        check("pre_rst_pass", pass_count, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_pass", pass_count, 0);
        check("async_rst_ready", bus.exp_ready, 1);
        check("async_rst_done", done, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        set_entry(THREE, 5'b0, 2'd0, FADD, 1'b0);
        bus.exp_valid  = 1'b1;
        bus.res_result = THREE;
        bus.res_flags  = 5'b0;
        bus.res_ready  = 1'b1;
        @(posedge clock); #1;
        bus.exp_valid = 1'b0;
        bus.res_ready = 1'b0;
        check("flushed_overrun", overrun, 1);
        check("flushed_pass", pass_count, 0);
        complete(THREE, 5'b0);
        check("nobypass_push_kept", pass_count, 1);
        check("nobypass_fail", fail_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
